// File: rtl/stream_sync_fifo.sv
// Single-clock streaming FIFO with DEPTH-entry capacity (pointer wrap bit), FWFT or
// registered read port, occupancy count, almost flags, flush and high-watermark.
module stream_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      hwm,
    input  logic                  clr_hwm
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a word moves on the write side when s_valid && s_ready at a rising
    // edge; on the read side (FWFT) when m_valid && m_ready. In standard mode m_ready
    // is a read enable and the popped word appears registered one cycle later.

    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      hwm_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  push;
    logic                  pop;
    logic                  empty_i;
    logic                  full_i;

    assign empty_i = (wr_ptr == rd_ptr);
    assign full_i  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // s_ready is held low while reset is applied so nothing is accepted then.
    assign s_ready      = rst_n && !full_i;
    assign push         = s_valid && s_ready;
    assign full         = full_i;
    assign empty        = empty_i;
    assign count        = count_q;
    assign hwm          = hwm_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Watermark follows the registered count, so it lags occupancy by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_hwm) begin
            hwm_q <= '0;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign m_valid = !empty_i;
            assign m_data  = mem[rd_ptr[AW-1:0]];
            assign pop     = m_valid && m_ready;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] m_data_q;
            logic                  m_valid_q;

            assign pop     = m_ready && !empty_i;
            assign m_data  = m_data_q;
            assign m_valid = m_valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    m_data_q  <= '0;
                    m_valid_q <= 1'b0;
                end else if (flush) begin
                    m_valid_q <= 1'b0;
                end else begin
                    m_valid_q <= pop;
                    if (pop) m_data_q <= mem[rd_ptr[AW-1:0]];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stream_sync_fifo.sv
// Directed bench for stream_sync_fifo: one FWFT instance and one standard-read
// instance, both DATA_WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1.
module tb_stream_sync_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance (a_*)
    logic       a_rst_n, a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [7:0] a_s_data, a_m_data;
    logic [2:0] a_count, a_hwm;
    logic       a_full, a_empty, a_af, a_ae, a_clr_hwm;

    // Standard-read instance (b_*)
    logic       b_rst_n, b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [7:0] b_s_data, b_m_data;
    logic [2:0] b_count, b_hwm;
    logic       b_full, b_empty, b_af, b_ae, b_clr_hwm;

    stream_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .count(a_count), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .hwm(a_hwm), .clr_hwm(a_clr_hwm)
    );

    stream_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .count(b_count), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .hwm(b_hwm), .clr_hwm(b_clr_hwm)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [7:0] d);
        a_s_data  = d;
        a_s_valid = 1'b1;
        step();
        a_s_valid = 1'b0;
    endtask

    task automatic b_push(input logic [7:0] d);
        b_s_data  = d;
        b_s_valid = 1'b1;
        step();
        b_s_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        a_rst_n = 1'b0; a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
        a_s_data = 8'h00; a_clr_hwm = 1'b0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0;
        b_s_data = 8'h00; b_clr_hwm = 1'b0;
        step();
        check("s_ready_in_reset", a_s_ready, 1'b0);
        step();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_count", a_count, 3'd0);
        check("rst_empty", a_empty, 1'b1);
        check("rst_full", a_full, 1'b0);
        check("rst_s_ready", a_s_ready, 1'b1);
        check("rst_ae", a_ae, 1'b1);
        check("rst_af", a_af, 1'b0);
        check("rst_m_valid", a_m_valid, 1'b0);
        check("rst_hwm", a_hwm, 3'd0);
        check("rst_std_m_valid", b_m_valid, 1'b0);
        check("rst_std_m_data", b_m_data, 8'h00);

        // 1. Single word through the FWFT port
        a_push(8'hA1);
        check("t1_m_valid", a_m_valid, 1'b1);
        check("t1_m_data", a_m_data, 8'hA1);
        check("t1_count", a_count, 3'd1);
        check("t1_ae", a_ae, 1'b1);
        a_m_ready = 1'b1;
        step();
        a_m_ready = 1'b0;
        check("t1_empty", a_empty, 1'b1);
        check("t1_count0", a_count, 3'd0);

        // 2. Fill to full with the consumer stalled
        for (int i = 1; i <= 4; i++) begin
            a_s_data  = 8'(i);
            a_s_valid = 1'b1;
            exp_q.push_back(8'(i));
            step();
        end
        a_s_data = 8'h05;
        check("t2_full", a_full, 1'b1);
        check("t2_s_ready", a_s_ready, 1'b0);
        check("t2_count", a_count, 3'd4);
        check("t2_af", a_af, 1'b1);
        check("t2_m_data_held", a_m_data, 8'h01);
        step();
        check("t2_refused_count", a_count, 3'd4);
        check("t2_hwm", a_hwm, 3'd4);

        // 3. Full with push and pop together: pop wins, push waits a cycle
        a_m_ready = 1'b1;
        e = exp_q.pop_front();
        check("t3_head", a_m_data, e);
        step();
        a_m_ready = 1'b0;
        check("t3_count3", a_count, 3'd3);
        check("t3_s_ready", a_s_ready, 1'b1);
        exp_q.push_back(8'h05);
        step();
        a_s_valid = 1'b0;
        check("t3_count4", a_count, 3'd4);
        a_m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            check("t3_drain_valid", a_m_valid, 1'b1);
            check("t3_drain_data", a_m_data, e);
            step();
        end
        a_m_ready = 1'b0;
        check("t3_empty", a_empty, 1'b1);

        // 4. Streaming at count=2 across pointer wrap
        a_push(8'hE0); exp_q.push_back(8'hE0);
        a_push(8'hE1); exp_q.push_back(8'hE1);
        check("t4_ae_off", a_ae, 1'b0);
        check("t4_af_off", a_af, 1'b0);
        a_m_ready = 1'b1;
        a_s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_s_data = 8'h10 + 8'(i);
            e = exp_q.pop_front();
            check("t4_data", a_m_data, e);
            exp_q.push_back(8'h10 + 8'(i));
            step();
            check("t4_count", a_count, 3'd2);
            check("t4_no_full", a_full, 1'b0);
            check("t4_no_empty", a_empty, 1'b0);
        end
        a_s_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            check("t4_tail", a_m_data, e);
            step();
        end
        a_m_ready = 1'b0;
        check("t4_drained", a_empty, 1'b1);

        // 5. Standard registered read port
        b_push(8'h55);
        b_push(8'h66);
        check("t5_count", b_count, 3'd2);
        check("t5_idle_valid", b_m_valid, 1'b0);
        b_m_ready = 1'b1;
        step();
        b_m_ready = 1'b0;
        check("t5_v1", b_m_valid, 1'b1);
        check("t5_d1", b_m_data, 8'h55);
        step();
        check("t5_gap_valid", b_m_valid, 1'b0);
        check("t5_gap_hold", b_m_data, 8'h55);
        b_m_ready = 1'b1;
        step();
        b_m_ready = 1'b0;
        check("t5_v2", b_m_valid, 1'b1);
        check("t5_d2", b_m_data, 8'h66);
        b_m_ready = 1'b1;
        step();
        b_m_ready = 1'b0;
        check("t5_empty_read_valid", b_m_valid, 1'b0);
        check("t5_empty_read_hold", b_m_data, 8'h66);
        check("t5_empty_count", b_count, 3'd0);

        // 6. Flush together with clr_hwm, then mid-stream reset
        a_push(8'hC1);
        a_push(8'hC2);
        a_push(8'hC3);
        check("t6_count3", a_count, 3'd3);
        a_flush = 1'b1; a_clr_hwm = 1'b1; a_s_valid = 1'b1; a_s_data = 8'hDD;
        step();
        a_flush = 1'b0; a_clr_hwm = 1'b0; a_s_valid = 1'b0;
        check("t6_flush_count", a_count, 3'd0);
        check("t6_flush_empty", a_empty, 1'b1);
        check("t6_flush_m_valid", a_m_valid, 1'b0);
        check("t6_flush_hwm", a_hwm, 3'd0);

        b_push(8'h71);
        b_push(8'h72);
        b_push(8'h73);
        step();
        check("t6_std_hwm", b_hwm, 3'd3);
        b_flush = 1'b1; b_clr_hwm = 1'b1; b_m_ready = 1'b1; b_s_valid = 1'b1;
        step();
        b_flush = 1'b0; b_clr_hwm = 1'b0; b_m_ready = 1'b0; b_s_valid = 1'b0;
        check("t6_std_count", b_count, 3'd0);
        check("t6_std_empty", b_empty, 1'b1);
        check("t6_std_m_valid", b_m_valid, 1'b0);
        check("t6_std_hwm0", b_hwm, 3'd0);
        check("t6_std_m_data_held", b_m_data, 8'h66);

        a_push(8'hB1);
        a_push(8'hB2);
        step();
        check("t6_hwm_resumed", a_hwm, 3'd2);
        a_rst_n = 1'b0; a_s_valid = 1'b1; a_s_data = 8'hB3;
        #1;
        check("t6_rst_s_ready_low", a_s_ready, 1'b0);
        step();
        a_rst_n = 1'b1; a_s_valid = 1'b0;
        #1;
        check("t6_rst_count", a_count, 3'd0);
        check("t6_rst_empty", a_empty, 1'b1);
        check("t6_rst_m_valid", a_m_valid, 1'b0);
        check("t6_rst_hwm", a_hwm, 3'd0);
        check("t6_rst_s_ready", a_s_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
